// File: rtl/ipl_copy_master.sv
// Wishbone B.4 pipelined master: each request reads one word from the IPL source
// region and writes it to the destination region, one transaction per bus cycle.
module ipl_copy_master #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] IPL_READ_ADDR  = 16'hF000,
    parameter logic [ADDR_WIDTH-1:0] IPL_WRITE_ADDR = 16'h0000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dreq_i,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  dack_o
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, GAP, WR_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, dack_q, dack_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, latch_q, latch_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            dack_q   <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rd_cnt_q <= IPL_READ_ADDR;
            wr_cnt_q <= IPL_WRITE_ADDR;
            latch_q  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            dack_q   <= dack_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            latch_q  <= latch_d;
        end
    end

    // Strobe, address and write data default low: each is held for a single clock.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = 1'b0;
        we_d     = we_q;
        dack_d   = 1'b0;
        adr_d    = '0;
        dat_d    = '0;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        latch_d  = latch_q;
        case (state_q)
            IDLE: begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                if (dreq_i) begin
                    state_d = RD_WAIT;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = rd_cnt_q;
                end
            end
            RD_WAIT: begin
                if (ack_i) begin
                    latch_d = dat_i;
                    cyc_d   = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = WR_WAIT;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = wr_cnt_q;
                dat_d   = latch_q;
            end
            WR_WAIT: begin
                if (ack_i) begin
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    dack_d   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    assign adr_o  = adr_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign dat_o  = dat_q;
    assign dack_o = dack_q;

endmodule

// File: tb/tb_ipl_copy_master.sv
// Bench for ipl_copy_master: directed scenarios plus a randomized slave checked
// against a transaction-level scoreboard of expected copy addresses and data.
module tb_ipl_copy_master;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        dreq_i = 1'b0;
    logic        ack_i = 1'b0;
    logic [15:0] dat_i = 16'h0;
    logic [15:0] adr_o, dat_o;
    logic        cyc_o, stb_o, we_o, dack_o;

    int vectors = 0;
    int miscompares = 0;

    ipl_copy_master #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16),
        .IPL_READ_ADDR(16'hF000), .IPL_WRITE_ADDR(16'h0000)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .dreq_i(dreq_i),
        .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i), .dack_o(dack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; dreq_i = 1'b0; ack_i = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, dack_o, adr_o, dat_o} !== 36'h0) begin
            $display("FAIL in_reset got %h want 0", {cyc_o, stb_o, we_o, dack_o, adr_o, dat_o});
            miscompares++;
        end
        reset_i = 1'b1;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, dack_o, adr_o, dat_o} !== 36'h0) begin
            $display("FAIL after_reset got %h want 0", {cyc_o, stb_o, we_o, dack_o, adr_o, dat_o});
            miscompares++;
        end
    endtask

    task automatic test_copy();
        logic [15:0] d;
        dreq_i = 1'b1; ack_i = 1'b0;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o} !== {3'b110, 16'hF000}) begin
            $display("FAIL rd_strobe got %h want %h", {cyc_o, stb_o, we_o, adr_o}, {3'b110, 16'hF000});
            miscompares++;
        end
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o} !== {3'b100, 16'h0}) begin
            $display("FAIL rd_wait got %h want %h", {cyc_o, stb_o, we_o, adr_o}, {3'b100, 16'h0});
            miscompares++;
        end
        ack_i = 1'b1; dat_i = 16'hBEEF;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o} !== 19'h0) begin
            $display("FAIL rd_ack got %h want 0", {cyc_o, stb_o, we_o, adr_o});
            miscompares++;
        end
        ack_i = 1'b0; dat_i = 16'h0;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== {3'b111, 16'h0000, 16'hBEEF}) begin
            $display("FAIL wr_strobe got %h want %h", {cyc_o, stb_o, we_o, adr_o, dat_o}, {3'b111, 16'h0000, 16'hBEEF});
            miscompares++;
        end
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, dack_o, adr_o, dat_o} !== {4'b1010, 32'h0}) begin
            $display("FAIL wr_wait got %h want %h", {cyc_o, stb_o, we_o, dack_o, adr_o, dat_o}, {4'b1010, 32'h0});
            miscompares++;
        end
        ack_i = 1'b1;
        tick();
        vectors++;
        if ({cyc_o, we_o, dack_o} !== 3'b001) begin
            $display("FAIL wr_ack got %b want 001", {cyc_o, we_o, dack_o});
            miscompares++;
        end
        ack_i = 1'b0;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, dack_o, adr_o} !== {4'b1100, 16'hF001}) begin
            $display("FAIL rd2_strobe got %h want %h", {cyc_o, stb_o, we_o, dack_o, adr_o}, {4'b1100, 16'hF001});
            miscompares++;
        end
        // Zero-wait ack on both halves of the second copy.
        d = 16'($urandom);
        ack_i = 1'b1; dat_i = d;
        tick();
        vectors++;
        if ({cyc_o, stb_o} !== 2'b00) begin
            $display("FAIL rd2_zero_wait got %b want 00", {cyc_o, stb_o});
            miscompares++;
        end
        ack_i = 1'b0; dreq_i = 1'b0; dat_i = ~d;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== {3'b111, 16'h0001, d}) begin
            $display("FAIL wr2_strobe got %h want %h", {cyc_o, stb_o, we_o, adr_o, dat_o}, {3'b111, 16'h0001, d});
            miscompares++;
        end
        ack_i = 1'b1;
        tick();
        vectors++;
        if ({cyc_o, dack_o} !== 2'b01) begin
            $display("FAIL wr2_ack got %b want 01", {cyc_o, dack_o});
            miscompares++;
        end
        ack_i = 1'b0;
        tick();
        vectors++;
        if ({cyc_o, stb_o, dack_o} !== 3'b000) begin
            $display("FAIL idle_after got %b want 000", {cyc_o, stb_o, dack_o});
            miscompares++;
        end
    endtask

    task automatic test_ack_stuck_idle();
        dreq_i = 1'b0; ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dat_i = 16'($urandom);
            tick();
            vectors++;
            if ({cyc_o, stb_o, dack_o} !== 3'b000) begin
                $display("FAIL ack_stuck_idle cycle %0d got %b want 000", i, {cyc_o, stb_o, dack_o});
                miscompares++;
            end
        end
        ack_i = 1'b0;
    endtask

    // Counters stand at F002/0002 after test_copy; ack held high throughout.
    task automatic test_back_to_back();
        logic [15:0] d, ra, wa;
        ra = 16'hF002; wa = 16'h0002;
        dreq_i = 1'b1; ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({cyc_o, stb_o, we_o, dack_o, adr_o} !== {4'b1100, ra}) begin
                $display("FAIL b2b_rd[%0d] got %h want %h", k, {cyc_o, stb_o, we_o, dack_o, adr_o}, {4'b1100, ra});
                miscompares++;
            end
            d = 16'($urandom); dat_i = d;
            tick();
            vectors++;
            if (cyc_o !== 1'b0) begin
                $display("FAIL b2b_gap[%0d] got cyc %b want 0", k, cyc_o);
                miscompares++;
            end
            dat_i = ~d;
            tick();
            vectors++;
            if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== {3'b111, wa, d}) begin
                $display("FAIL b2b_wr[%0d] got %h want %h", k, {cyc_o, stb_o, we_o, adr_o, dat_o}, {3'b111, wa, d});
                miscompares++;
            end
            tick();
            vectors++;
            if ({cyc_o, dack_o} !== 2'b01) begin
                $display("FAIL b2b_dack[%0d] got %b want 01", k, {cyc_o, dack_o});
                miscompares++;
            end
            ra = ra + 16'd1; wa = wa + 16'd1;
        end
        dreq_i = 1'b0; ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        dreq_i = 1'b1; ack_i = 1'b0;
        tick();
        dreq_i = 1'b0;
        tick();
        #2 reset_i = 1'b0;
        #1;
        vectors++;
        if ({cyc_o, stb_o, we_o} !== 3'b000) begin
            $display("FAIL async_reset got %b want 000", {cyc_o, stb_o, we_o});
            miscompares++;
        end
        @(posedge clk_i); #1;
        reset_i = 1'b1; dreq_i = 1'b1;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o} !== {3'b110, 16'hF000}) begin
            $display("FAIL reset_reload got %h want %h", {cyc_o, stb_o, we_o, adr_o}, {3'b110, 16'hF000});
            miscompares++;
        end
        dreq_i = 1'b0; ack_i = 1'b1; dat_i = 16'h1234;
        tick();
        ack_i = 1'b0;
        tick();
        vectors++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== {3'b111, 16'h0000, 16'h1234}) begin
            $display("FAIL reset_wr got %h want %h", {cyc_o, stb_o, we_o, adr_o, dat_o}, {3'b111, 16'h0000, 16'h1234});
            miscompares++;
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
    endtask

    // Random slave with 0..3 wait states and garbage ack while cyc_o is low;
    // the scoreboard tracks only copy progress, addresses and captured data.
    task automatic test_random();
        logic [15:0] rd_a, wr_a, last_rd;
        bit busy, waiting, is_wr, in_gap, seen;
        bit e_rd, e_wr, e_dack, e_low, e_hold;
        int dly;
        rd_a = 16'hF000; wr_a = 16'h0000; last_rd = 16'h0;
        busy = 0; waiting = 0; is_wr = 0; in_gap = 0;
        e_rd = 0; e_wr = 0; e_dack = 0; e_low = 0; e_hold = 0; dly = 0;
        reset_i = 1'b0; dreq_i = 1'b0; ack_i = 1'b0;
        repeat (2) tick();
        reset_i = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            seen = e_rd | e_wr;
            if (seen) begin
                waiting = 1; is_wr = e_wr; dly = $urandom_range(0, 3);
            end
            e_rd = 0; e_wr = 0; e_dack = 0; e_low = 0;
            dat_i  = 16'($urandom);
            dreq_i = 1'($urandom);
            if (waiting) begin
                if (dly == 0) begin
                    ack_i = 1'b1; waiting = 0; e_low = 1;
                    if (is_wr) begin
                        e_dack = 1; busy = 0;
                        rd_a = rd_a + 16'd1; wr_a = wr_a + 16'd1;
                    end else begin
                        last_rd = dat_i; in_gap = 1;
                    end
                end else begin
                    ack_i = 1'b0; dly--;
                end
            end else begin
                ack_i = 1'($urandom);
                if (in_gap) begin
                    in_gap = 0; e_wr = 1;
                end else if (!busy && dreq_i) begin
                    busy = 1; e_rd = 1;
                end
            end
            e_hold = waiting;
            tick();
            vectors++;
            if (stb_o !== (e_rd | e_wr)) begin
                $display("FAIL rnd_stb n=%0d got %b want %b", n, stb_o, e_rd | e_wr);
                miscompares++;
            end
            vectors++;
            if (dack_o !== e_dack) begin
                $display("FAIL rnd_dack n=%0d got %b want %b", n, dack_o, e_dack);
                miscompares++;
            end
            if (e_rd) begin
                vectors++;
                if ({cyc_o, we_o, adr_o, dat_o} !== {2'b10, rd_a, 16'h0}) begin
                    $display("FAIL rnd_rd n=%0d got %h want %h", n, {cyc_o, we_o, adr_o, dat_o}, {2'b10, rd_a, 16'h0});
                    miscompares++;
                end
            end
            if (e_wr) begin
                vectors++;
                if ({cyc_o, we_o, adr_o, dat_o} !== {2'b11, wr_a, last_rd}) begin
                    $display("FAIL rnd_wr n=%0d got %h want %h", n, {cyc_o, we_o, adr_o, dat_o}, {2'b11, wr_a, last_rd});
                    miscompares++;
                end
            end
            if (!e_rd && !e_wr) begin
                vectors++;
                if ({adr_o, dat_o} !== 32'h0) begin
                    $display("FAIL rnd_quiet n=%0d got %h want 0", n, {adr_o, dat_o});
                    miscompares++;
                end
            end
            if (e_low || (!busy && !e_rd)) begin
                vectors++;
                if (cyc_o !== 1'b0) begin
                    $display("FAIL rnd_cyc_low n=%0d got %b want 0", n, cyc_o);
                    miscompares++;
                end
            end
            if (e_hold && !e_rd && !e_wr) begin
                vectors++;
                if ({cyc_o, we_o} !== {1'b1, is_wr}) begin
                    $display("FAIL rnd_hold n=%0d got %b want %b", n, {cyc_o, we_o}, {1'b1, is_wr});
                    miscompares++;
                end
            end
        end
        dreq_i = 1'b0; ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_copy();
        test_ack_stuck_idle();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
